clocks_cen_ctrl: RTL and testbench

Generates the `CLK_EN_24M_P` / `CLK_EN_24M_N` strobe pair that drives `clocks_sync` from the fast system clock. It uses a fractional accumulator, so any system clock frequency works. It lets one requester (typically the SDRAM/ROM fetch path) pause the whole NeoGeo timebase at a safe point, handshaking the pause with an acknowledge. It sits directly upstream of `clocks_sync` in the top-level clock tree.

---
 rtl/clocks_cen_ctrl.sv | 137 +++++++++++++
 tb/tb_clocks_cen_ctrl.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/clocks_cen_ctrl.sv
// clocks_cen_ctrl: fractional clock-enable generator for the 24M P/N strobe
// pair feeding clocks_sync. It also provides a pause handshake that stops the
// timebase after a complete 24M period.
// Optional feature macro: CEN_CATCHUP_EN. When it is defined, events that fall
// while halted are counted as debt and replayed after release.
`timescale 1ns/1ps
module clocks_cen_ctrl #(
  parameter int NUM      = 1,
  parameter int DEN      = 2,
  parameter int MAX_DEBT = 15
) (
  input  logic       CLK,
  input  logic       nRESETP,
  input  logic       PAUSE_REQ,
  output logic       PAUSE_ACK,
  output logic       CLK_EN_24M_P,
  output logic       CLK_EN_24M_N,
  output logic [2:0] CEN_PHASE,
  output logic [3:0] CEN_DEBT
);
  // acc < DEN and NUM <= DEN, so acc + NUM < 2*DEN always fits in AW bits
  localparam int AW = $clog2(DEN) + 1;
  localparam logic [AW-1:0] NUM_W = AW'(NUM);
  localparam logic [AW-1:0] DEN_W = AW'(DEN);
  localparam logic [3:0]    MAX_W = 4'(MAX_DEBT);

`ifdef CEN_CATCHUP_EN
  localparam bit CATCHUP = 1'b1;
`else
  localparam bit CATCHUP = 1'b0;
`endif

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

  state_t        r_state;
  logic [AW-1:0] r_acc;
  logic          r_half;
  logic          r_p;
  logic          r_n;
  logic          r_ack;
  logic [2:0]    r_phase;
  logic [3:0]    r_debt;

  logic [AW-1:0] w_sum;
  logic [AW-1:0] w_acc_next;
  logic          w_event;
  logic          w_active;
  logic          w_acc_en;
  logic          w_debt_nz;
  logic          w_emit;
  logic          w_emit_n;

  assign w_sum      = r_acc + NUM_W;
  assign w_event    = (w_sum >= DEN_W);
  assign w_acc_next = w_event ? (w_sum - DEN_W) : w_sum;
  assign w_active   = (r_state != ST_HALT);
  // without catch-up the accumulator freezes while halted so no time is skipped
  assign w_acc_en   = w_active | CATCHUP;
  assign w_debt_nz  = (r_debt != 4'd0);
  // one strobe per cycle at most: a real event, or otherwise one replayed debt
  assign w_emit     = w_active & (w_event | w_debt_nz);
  assign w_emit_n   = w_emit & r_half;

  // timebase: accumulator, P/N alternation, phase shadow and pause state machine
  always_ff @(posedge CLK or negedge nRESETP) begin
    if (!nRESETP) begin
      r_state <= ST_RUN;
      r_acc   <= '0;
      r_half  <= 1'b0;
      r_p     <= 1'b0;
      r_n     <= 1'b0;
      r_ack   <= 1'b0;
      r_phase <= 3'b100;
    end else begin
      if (w_acc_en) begin
        r_acc <= w_acc_next;
      end
      r_p <= w_emit & ~r_half;
      r_n <= w_emit_n;
      if (w_emit) begin
        r_half <= ~r_half;
      end
      if (w_emit_n) begin
        r_phase <= r_phase + 3'd1;
      end
      // ack follows the halted state one cycle late and drops as HALT is left
      r_ack <= (r_state == ST_HALT) && PAUSE_REQ;
      case (r_state)
        ST_RUN: begin
          // an N computed on the request cycle does not end the drain
          if (PAUSE_REQ) begin
            r_state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (!PAUSE_REQ) begin
            r_state <= ST_RUN;
          end else if (w_emit_n) begin
            r_state <= ST_HALT;
          end
        end
        ST_HALT: begin
          if (!PAUSE_REQ) begin
            r_state <= ST_RUN;
          end
        end
        default: r_state <= ST_RUN;
      endcase
    end
  end

  // catch-up debt: collect events that fall while halted, repay on idle cycles
  always_ff @(posedge CLK or negedge nRESETP) begin
    if (!nRESETP) begin
      r_debt <= 4'd0;
    end else if (CATCHUP) begin
      if (!w_active) begin
        if (w_event && (r_debt != MAX_W)) begin
          r_debt <= r_debt + 4'd1;
        end
      end else if (!w_event && w_debt_nz) begin
        r_debt <= r_debt - 4'd1;
      end
    end
  end

  assign PAUSE_ACK    = r_ack;
  assign CLK_EN_24M_P = r_p;
  assign CLK_EN_24M_N = r_n;
  assign CEN_PHASE    = r_phase;
  assign CEN_DEBT     = r_debt;

endmodule

// File: tb/tb_clocks_cen_ctrl.sv
// Bench for clocks_cen_ctrl: four instances with different NUM/DEN ratios run
// side by side against a rate-based reference model, plus directed checks of
// the strobe edges, pause handshake, catch-up debt and asynchronous reset.
`timescale 1ns/1ps
module tb_clocks_cen_ctrl;
  localparam int ND   = 4;
  localparam int MAXD = 15;
  localparam int M_RUN   = 0;
  localparam int M_DRAIN = 1;
  localparam int M_HALT  = 2;
`ifdef CEN_CATCHUP_EN
  localparam bit CU = 1'b1;
`else
  localparam bit CU = 1'b0;
`endif

  function automatic int num_of(input int i);
    case (i)
      1:       return 3;
      3:       return 2;
      default: return 1;
    endcase
  endfunction

  function automatic int den_of(input int i);
    case (i)
      0:       return 2;
      1:       return 8;
      2:       return 4;
      default: return 2;
    endcase
  endfunction

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req   [ND];
  logic       ack_o [ND];
  logic       p_o   [ND];
  logic       n_o   [ND];
  logic [2:0] ph_o  [ND];
  logic [3:0] db_o  [ND];

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < ND; gi++) begin : g_dut
    clocks_cen_ctrl #(
      .NUM      (num_of(gi)),
      .DEN      (den_of(gi)),
      .MAX_DEBT (MAXD)
    ) u_dut (
      .CLK          (clk),
      .nRESETP      (rst_n),
      .PAUSE_REQ    (req[gi]),
      .PAUSE_ACK    (ack_o[gi]),
      .CLK_EN_24M_P (p_o[gi]),
      .CLK_EN_24M_N (n_o[gi]),
      .CEN_PHASE    (ph_o[gi]),
      .CEN_DEBT     (db_o[gi])
    );
  end

  // reference model: events come from the rate n*NUM/DEN, strobes from event parity
  int         m_n    [ND];
  int         m_e    [ND];
  int         m_mode [ND];
  int         m_debt [ND];
  bit         exp_p  [ND];
  bit         exp_nn [ND];
  bit         exp_ack[ND];
  logic [2:0] exp_ph [ND];
  int         cnt_s  [ND];
  int         cyc;
  int         n_checks;
  int         n_fail;

  function automatic bit ev_at(input int i, input int n);
    return (((n + 1) * num_of(i)) / den_of(i)) > ((n * num_of(i)) / den_of(i));
  endfunction

  task automatic model_reset();
    for (int i = 0; i < ND; i++) begin
      m_n[i] = 0; m_e[i] = 0; m_mode[i] = M_RUN; m_debt[i] = 0;
      exp_p[i] = 1'b0; exp_nn[i] = 1'b0; exp_ack[i] = 1'b0; exp_ph[i] = 3'd4;
      cnt_s[i] = 0;
    end
    cyc = 0;
  endtask

  task automatic model_step(input int i, input bit r);
    bit emit;
    bit isn;
    bit ev;
    emit = 1'b0;
    if (m_mode[i] != M_HALT) begin
      ev = ev_at(i, m_n[i]);
      m_n[i]++;
      if (ev) emit = 1'b1;
      else if (CU && m_debt[i] > 0) begin
        emit = 1'b1;
        m_debt[i]--;
      end
    end else if (CU) begin
      ev = ev_at(i, m_n[i]);
      m_n[i]++;
      if (ev && m_debt[i] < MAXD) m_debt[i]++;
    end
    isn = emit && (m_e[i] % 2 == 1);
    exp_p[i]   = emit && !isn;
    exp_nn[i]  = isn;
    exp_ack[i] = (m_mode[i] == M_HALT) && r;
    if (emit) m_e[i]++;
    if (isn) exp_ph[i] = exp_ph[i] + 3'd1;
    case (m_mode[i])
      M_RUN:   if (r) m_mode[i] = M_DRAIN;
      M_DRAIN: if (!r) m_mode[i] = M_RUN; else if (isn) m_mode[i] = M_HALT;
      default: if (!r) m_mode[i] = M_RUN;
    endcase
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    assert (got === want) else begin
      n_fail++;
      $error("FAIL %s cyc=%0d got=%0d want=%0d", tag, cyc, got, want);
    end
  endtask

  // one clock: advance the model, take the edge, compare every instance
  task automatic tick();
    for (int i = 0; i < ND; i++) model_step(i, req[i]);
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < ND; i++) begin
      logic [9:0] got;
      logic [9:0] want;
      got  = {p_o[i], n_o[i], ack_o[i], ph_o[i], db_o[i]};
      want = {exp_p[i], exp_nn[i], exp_ack[i], exp_ph[i], 4'(m_debt[i])};
      n_checks++;
      assert (got === want) else begin
        n_fail++;
        $error("FAIL model dut%0d cyc=%0d got=%b want=%b (p,n,ack,phase,debt)", i, cyc, got, want);
      end
      if (p_o[i] === 1'b1 || n_o[i] === 1'b1) cnt_s[i]++;
    end
  endtask

  task automatic wait_halt(input int i, input string tag);
    bit found;
    found = 1'b0;
    for (int k = 0; k < 24 && !found; k++) begin
      tick();
      if (m_mode[i] == M_HALT) found = 1'b1;
    end
    chk(tag, 32'(found), 32'd1);
  endtask

  initial begin
    bit found;
    int halted_strobes;
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    for (int i = 0; i < ND; i++) req[i] = 1'b0;
    model_reset();

    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < ND; i++)
      chk("reset_state", {22'd0, p_o[i], n_o[i], ack_o[i], ph_o[i], db_o[i]}, {22'd0, 3'b000, 3'b100, 4'd0});
    $display("step reset: outputs checked while nRESETP low");

    @(negedge clk);
    rst_n = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      tick();
      chk("u0_p_edge", 32'(p_o[0]), 32'((e % 4) == 2));
      chk("u0_n_edge", 32'(n_o[0]), 32'((e % 4) == 0));
      chk("u0_phase", 32'(ph_o[0]), 32'(4 + e / 4));
    end
    $display("step release: first 10 edges of NUM=1 DEN=2 checked");

    while (cyc < 800) tick();
    chk("u1_count_3_8", 32'(cnt_s[1]), 32'd300);
    chk("u0_count_1_2", 32'(cnt_s[0]), 32'd400);
    chk("u2_count_1_4", 32'(cnt_s[2]), 32'd200);
    chk("u3_count_2_2", 32'(cnt_s[3]), 32'd800);
    $display("step free-run: 800 cycles, strobe totals checked");

    found = 1'b0;
    for (int k = 0; k < 8 && !found; k++) begin
      tick();
      if (p_o[0] === 1'b1) found = 1'b1;
    end
    chk("u0_wait_p", 32'(found), 32'd1);
    req[0] = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 8 && !found; k++) begin
      tick();
      if (n_o[0] === 1'b1) found = 1'b1;
    end
    chk("u0_drain_n", 32'(found), 32'd1);
    chk("u0_ack_with_n", 32'(ack_o[0]), 32'd0);
    tick();
    chk("u0_ack_rise", 32'(ack_o[0]), 32'd1);
    halted_strobes = cnt_s[0];
    repeat (10) tick();
    chk("u0_halt_quiet", 32'(cnt_s[0] - halted_strobes), 32'd0);
    chk("u0_ack_hold", 32'(ack_o[0]), 32'd1);
    req[0] = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 8 && !found; k++) begin
      tick();
      if (p_o[0] === 1'b1 || n_o[0] === 1'b1) found = 1'b1;
    end
    chk("u0_resume_seen", 32'(found), 32'd1);
    chk("u0_resume_p", {30'd0, p_o[0], n_o[0]}, 32'b10);
    $display("step pause: u0 drained on N, acked, halted, resumed on P");

    repeat (3) tick();
    req[0] = 1'b1;
    tick();
    req[0] = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      chk("u0_pulse_noack", 32'(ack_o[0]), 32'd0);
    end
    $display("step pulse: one-cycle request left ack low");

    req[2] = 1'b1;
    wait_halt(2, "u2_enter_halt");
    repeat (40) tick();
    chk("u2_debt_40", 32'(db_o[2]), (CU ? 32'd10 : 32'd0));
    chk("u2_ack", 32'(ack_o[2]), 32'd1);
    req[2] = 1'b0;
    repeat (200) tick();
`ifdef CEN_CATCHUP_EN
    chk("u2_recovered", 32'(cnt_s[2]), 32'(cyc / 4));
`endif
    chk("u2_count_model", 32'(cnt_s[2]), 32'(m_e[2]));
    $display("step catch-up: 40-cycle halt and recovery checked");

    req[2] = 1'b1;
    wait_halt(2, "u2_enter_halt2");
    repeat (200) tick();
    chk("u2_debt_sat", 32'(db_o[2]), (CU ? 32'd15 : 32'd0));
    req[2] = 1'b0;
    repeat (100) tick();
    $display("step saturate: 200-cycle halt checked");

    req[2] = 1'b1;
    wait_halt(2, "u2_enter_halt3");
    repeat (28) tick();
    chk("u2_debt_28", 32'(db_o[2]), (CU ? 32'd7 : 32'd0));
    #2;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < ND; i++)
      chk("async_reset", {22'd0, p_o[i], n_o[i], ack_o[i], ph_o[i], db_o[i]}, {22'd0, 3'b000, 3'b100, 4'd0});
    for (int i = 0; i < ND; i++) req[i] = 1'b0;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) tick();
    chk("post_reset_u0", 32'(cnt_s[0]), 32'd20);
    $display("step async reset: cleared mid-halt, restart checked");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
